// File: rtl/input_round_robin_arbiter.sv
// Round-robin scheduler of the 5 input-queue heads into the single routing stage.
// Latency: head to from_arbiter is combinational; the pointer moves 1 cycle after consume/empty/skip.
// Backpressure: a valid head that is not popped holds the grant for at most MAX_WAIT cycles, then it is skipped.
module input_round_robin_arbiter #(
    parameter int PL       = 16,
    parameter int CS       = 2,
    parameter int REN      = 5,
    parameter int REN_B    = 3,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:PL-1]     heads [REN],
    input  logic [REN-1:0]    pop,
    input  logic              enable,
    output logic [0:PL-1]     from_arbiter,
    output logic [REN_B-1:0]  shift,
    output logic              grant_valid,
    output logic [CNT_W-1:0]  skip_count,
    output logic [CNT_W-1:0]  grant_count,
    output logic              protocol_error
);

    if (2 * CS + 1 > PL || REN != 5 || MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_params
        $error("input_round_robin_arbiter: illegal parameter set");
    end

    localparam logic [REN_B-1:0] LAST_PORT = REN_B'(REN - 1);
    localparam logic [7:0]       WAIT_LIM  = 8'(MAX_WAIT - 1);

    logic [REN_B-1:0] ptr;
    logic [REN_B-1:0] ptr_nxt;
    logic [REN_B-1:0] ptr_inc;
    logic [7:0]       wait_cnt;
    logic [7:0]       wait_nxt;
    logic [0:PL-1]    head_sel;
    logic [REN-1:0]   ptr_oh;
    logic             head_vld;
    logic             pop_sel;
    logic             multi_pop;
    logic             stray_pop;
    logic             err_now;
    logic             consume;
    logic             skip;

    always_comb begin
        head_sel = '0;
        ptr_oh   = '0;
        for (int i = 0; i < REN; i++) begin
            if (ptr == REN_B'(i)) begin
                head_sel  = heads[i];
                ptr_oh[i] = 1'b1;
            end
        end
    end

    assign head_vld  = head_sel[0];
    assign pop_sel   = |(pop & ptr_oh);
    assign multi_pop = (pop & (pop - REN'(1))) != '0;
    assign stray_pop = |(pop & ~ptr_oh);
    // A pop on an empty selected head, or any pop while frozen, is also a protocol violation.
    assign err_now   = (!enable && (|pop)) || multi_pop || stray_pop ||
                       (enable && pop_sel && !head_vld);

    assign ptr_inc = (ptr == LAST_PORT) ? '0 : ptr + REN_B'(1);

    always_comb begin
        ptr_nxt  = ptr;
        wait_nxt = wait_cnt;
        consume  = 1'b0;
        skip     = 1'b0;
        if (enable) begin
            if (head_vld && pop_sel) begin
                ptr_nxt  = ptr_inc;
                wait_nxt = '0;
                consume  = 1'b1;
            end else if (!head_vld) begin
                ptr_nxt  = ptr_inc;
                wait_nxt = '0;
            end else if (wait_cnt == WAIT_LIM) begin
                ptr_nxt  = ptr_inc;
                wait_nxt = '0;
                skip     = 1'b1;
            end else begin
                wait_nxt = wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            wait_cnt       <= '0;
            skip_count     <= '0;
            grant_count    <= '0;
            protocol_error <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            wait_cnt <= wait_nxt;
            if (consume && (grant_count != '1)) begin
                grant_count <= grant_count + CNT_W'(1);
            end
            if (skip && (skip_count != '1)) begin
                skip_count <= skip_count + CNT_W'(1);
            end
            if (err_now) begin
                protocol_error <= 1'b1;
            end
        end
    end

    assign from_arbiter = (enable && head_vld) ? head_sel : '0;
    assign shift        = ptr;
    assign grant_valid  = from_arbiter[0];

endmodule

// File: doc/input_round_robin_arbiter.md
Name: input_round_robin_arbiter

Overview:
- Per-router input scheduler that shares the single routing-decision stage between the 5 input-port queues: core, north, east, south, west.
- Each cycle it selects one queue head and presents it as from_arbiter, with the selected index on shift.
- It advances on a consumed flit, an empty head, or a blocked head that exceeds a wait limit, so one stalled port cannot starve the others.
- Sits between the input FIFOs and the routing-algorithm block in every mesh router.

Parameters:
- PL, 16, packet width in bits; bit 0 is valid, bits 1..CS are dest X, bits CS+1..2*CS are dest Y.
- CS, 2, coordinate width.
- REN, 5, number of input ports; fixed at 5.
- REN_B, 3, index width, equal to clog2(REN).
- MAX_WAIT, 8, cycles a valid but unconsumed head may hold the grant before being skipped; legal range 2..255.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- heads  input  [0:PL-1] x REN  head flit of each input queue; bit 0 = valid
- pop  input  1 x REN  per-port consume strobes from the routing stage (its shift_signals)
- enable  input  1  0 freezes the pointer and wait counter and forces from_arbiter to zero
- from_arbiter  output  [0:PL-1]  selected head flit; all-zero when the selected head is invalid or enable=0
- shift  output  REN_B  selected port index, equal to ptr
- grant_valid  output  1  equals from_arbiter[0]
- skip_count  output  CNT_W  saturating count of wait-limit skips
- grant_count  output  CNT_W  saturating count of consumed flits
- protocol_error  output  1  sticky; set when pop is asserted on a non-selected port or more than one pop is asserted in a cycle

Behaviour:
- Reset is asynchronous. On reset: ptr=0, wait_cnt=0, skip_count=0, grant_count=0, protocol_error=0. from_arbiter follows heads[0] gated by enable; shift=0.
- Presentation is combinational from the registered ptr: from_arbiter = enable & heads[ptr][0] ? heads[ptr] : 0. This gives zero-cycle latency from head to routing stage, and a 1-cycle pointer update after an event.
- next(p) = (p==REN-1) ? 0 : p+1. ptr never takes values 5..7.
- Per rising edge with enable=1, evaluate in priority order:
  - E1 CONSUME: pop[ptr]=1 and heads[ptr][0]=1 → ptr<=next(ptr), wait_cnt<=0, grant_count+=1 (saturating at all-ones).
  - E2 EMPTY: heads[ptr][0]=0 → ptr<=next(ptr), wait_cnt<=0. Any pop[ptr] in this cycle is a protocol_error.
  - E3 BLOCKED: valid head and no pop[ptr].
    - If wait_cnt==MAX_WAIT-1: ptr<=next(ptr), wait_cnt<=0, skip_count+=1 (saturating).
    - Otherwise wait_cnt+=1.
- Empty ports cost exactly one cycle each. With all 5 heads empty, ptr cycles 0→1→2→3→4→0.
- Any pop[i] with i!=ptr, or popcount(pop)>1, sets protocol_error in the same edge. That pop does not move ptr unless pop[ptr] also qualifies under E1. protocol_error clears only on rst.
- enable=0: ptr, wait_cnt and the counters hold. from_arbiter=0 and grant_valid=0. Pops in this cycle set protocol_error.
- A head that goes invalid mid-wait is handled by E2 on that edge; wait_cnt resets.
- A rst assertion mid-wait discards wait_cnt and ptr immediately, with no glitch-free requirement on the outputs during reset.
- Counter saturation: at all-ones the counter holds and never wraps.

Test Plan:
- Reset, all heads valid, pop[ptr] every cycle → shift sequence 0,1,2,3,4,0; grant_count=5 after 5 cycles; protocol_error=0.
- Only heads[3] valid (dest X=2, Y=1), pop[3] asserted when shift==3 → shift 0,1,2,3 then 4 on the next edge; ptr spends exactly one cycle on each empty port; grant_count=1.
- heads[1] valid, pop never asserted, MAX_WAIT=8 → shift==1 for exactly 8 cycles then moves to 2; skip_count=1; wait_cnt restarts at 0.
- pop[2] asserted while shift==0 → protocol_error=1 on the next edge and stays 1; ptr does not jump to 3.
- enable=0 for 10 cycles with ptr=4 and a valid head → from_arbiter=0, shift=4 holds; after enable=1 the wait count starts from its frozen value.
- Assert rst asynchronously mid-wait (wait_cnt=5, ptr=2) → ptr=0, counters=0 immediately without waiting for a clock edge; next wait limit is a full MAX_WAIT cycles.
